mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle core's unified instruction/data memory port.
- Samples the controller's read/write request (MemR/MemW with the IoD-muxed address) and performs a single-word access to internal RAM after a configurable number of wait states.
- Returns a one-cycle completion pulse and registered read data.
- Sits between the datapath address/write-data mux and the memory data register.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, request address width (word address)
- DEPTH_LOG2, 10, log2 of RAM depth in words; valid addresses 0..2**DEPTH_LOG2-1
- WAIT_CYCLES, 1, wait states between request sampling and completion (0..15)

Ports:
- CLK  in  1  clock; all state changes on rising edge
- Reset_n  in  1  reset; one clock, asynchronous, active-low
- req_read  in  1  read request (from MemR), level
- req_write  in  1  write request (from MemW), level
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- busy  out  1  high while an accepted access is in flight (WAIT or DONE)
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: access was rejected
- resp_rdata  out  DATA_W  registered read data, held until the next successful read

Behaviour:
- Reset (Reset_n=0, async):
  - state=IDLE; busy, resp_valid, resp_err = 0; resp_rdata = 0; wait counter = 0.
  - RAM contents are not cleared.
- States: IDLE, WAIT, DONE.
- IDLE:
  - busy=0.
  - On an edge with req_read|req_write=1: latch addr, wdata and op; load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else DONE.
- WAIT:
  - busy=1; counter decrements each edge.
  - Transition to DONE on the edge where counter==1.
- Entering DONE (the edge into DONE):
  - Valid write: RAM[addr] <= wdata.
  - Valid read: resp_rdata <= RAM[addr].
- DONE:
  - busy=1, resp_valid=1 for exactly one cycle; then IDLE unconditionally.
- Latency:
  - resp_valid is high in the cycle after the (WAIT_CYCLES+1)th edge following the sampling edge.
  - Minimum request spacing is WAIT_CYCLES+2 cycles.
- Request protocol:
  - Requests are level-sampled only in IDLE.
  - Requests or input changes during WAIT/DONE are ignored; latched values are used.
  - A request still asserted on the edge leaving DONE is not sampled; it is sampled on the following IDLE edge.
- Error cases (resp_err=1 together with resp_valid):
  - req_read and req_write both high at sampling: no RAM change, resp_rdata unchanged.
  - Latched addr >= 2**DEPTH_LOG2: write suppressed, resp_rdata unchanged.
- resp_err is 0 whenever resp_valid is 0.
- Reset asserted mid-access (WAIT or DONE entry pending): access aborted, pending write not performed, outputs forced to reset values.
- Address wrap: none. The upper address bits are checked, not truncated.

Optional Feature:
- Macro MEM_RESPONDER_STATS_EN.
- Defined:
  - Adds outputs stat_reads and stat_writes, 16 bits each.
  - Each counts successful (resp_err=0) completions of that type.
  - Increments on the edge entering DONE; saturates at 16'hFFFF; cleared by reset.
- Not defined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- WAIT_CYCLES=1, write addr 16'h0004 data 16'hBEEF -> busy=1 next cycle; resp_valid high 2 edges after sampling; resp_err=0.
- Then read addr 16'h0004 -> resp_rdata=16'hBEEF in the resp_valid cycle, held after valid drops; unrelated write to 16'h0005 leaves resp_rdata=16'hBEEF.
- req_read=req_write=1 at addr 16'h0004 with wdata 16'h1234 -> resp_valid=1, resp_err=1; subsequent read of 16'h0004 returns 16'hBEEF.
- DEPTH_LOG2=10, write addr 16'h0400 data 16'h5555 -> resp_err=1; read 16'h0000 unaffected; read 16'h0400 -> resp_err=1, resp_rdata unchanged.
- Write 16'h0010 data 16'hAAAA, assert Reset_n=0 during WAIT -> outputs zero immediately, state IDLE; later read of 16'h0010 does not return 16'hAAAA (preloaded 16'h0000 remains).
- WAIT_CYCLES=0, req_read held continuously -> resp_valid pulses every 2 cycles; with MEM_RESPONDER_STATS_EN, stat_reads=3 after 3 pulses.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's memory controller and mem_responder.
// The stat_* counters exist only when MEM_RESPONDER_STATS_EN is defined.
interface mem_responder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              req_read;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              busy;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
`ifdef MEM_RESPONDER_STATS_EN
    logic [15:0]       stat_reads;
    logic [15:0]       stat_writes;
`endif

    modport master (
        output req_read, req_write, req_addr, req_wdata,
        input  busy, resp_valid, resp_err, resp_rdata
`ifdef MEM_RESPONDER_STATS_EN
        , input stat_reads, stat_writes
`endif
    );

    modport slave (
        input  req_read, req_write, req_addr, req_wdata,
        output busy, resp_valid, resp_err, resp_rdata
`ifdef MEM_RESPONDER_STATS_EN
        , output stat_reads, stat_writes
`endif
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port RAM responder with programmable wait states and a one-cycle completion pulse.
// Define MEM_RESPONDER_STATS_EN to add saturating successful-read/write counters.
module mem_responder #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             Reset_n,
    mem_responder_if.slave   bus
);
    localparam logic [1:0]  IDLE      = 2'd0;
    localparam logic [1:0]  WAIT      = 2'd1;
    localparam logic [1:0]  DONE      = 2'd2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam int unsigned RAM_DEPTH = 1 << DEPTH_LOG2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_q, rd_d, wr_q, wr_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [RAM_DEPTH];

    // The access operands come straight from the bus when there are no wait states.
    logic              acc_fire, acc_rd, acc_wr, acc_err, acc_ok_rd, acc_ok_wr;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [DEPTH_LOG2-1:0] ram_idx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        acc_fire  = 1'b0;
        acc_rd    = rd_q;
        acc_wr    = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_read || bus.req_write) begin
                    rd_d    = bus.req_read;
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = DONE;
                        acc_fire  = 1'b1;
                        acc_rd    = bus.req_read;
                        acc_wr    = bus.req_write;
                        acc_addr  = bus.req_addr;
                        acc_wdata = bus.req_wdata;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = DONE;
                    acc_fire = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range addresses are rejected rather than wrapped onto the RAM.
    assign acc_err   = (acc_rd & acc_wr) | ((acc_addr >> DEPTH_LOG2) != '0);
    assign acc_ok_rd = acc_fire & acc_rd & ~acc_err & Reset_n;
    assign acc_ok_wr = acc_fire & acc_wr & ~acc_err & Reset_n;
    assign err_d     = acc_fire ? acc_err : err_q;
    assign ram_idx   = acc_addr[DEPTH_LOG2-1:0];

    always_ff @(posedge CLK) begin
        if (acc_ok_wr) begin
            mem[ram_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (acc_ok_rd) begin
                rdata_q <= mem[ram_idx];
            end
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_err   = (state_q == DONE) & err_q;
    assign bus.resp_rdata = rdata_q;

`ifdef MEM_RESPONDER_STATS_EN
    logic [15:0] stat_reads_q, stat_writes_q;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
        end else begin
            if (acc_ok_rd && stat_reads_q != 16'hFFFF) begin
                stat_reads_q <= stat_reads_q + 16'd1;
            end
            if (acc_ok_wr && stat_writes_q != 16'hFFFF) begin
                stat_writes_q <= stat_writes_q + 16'd1;
            end
        end
    end

    assign bus.stat_reads  = stat_reads_q;
    assign bus.stat_writes = stat_writes_q;
`endif
endmodule
